// File: rtl/systolic_array_engine.sv
// Weight-stationary systolic matrix-multiply engine.
// Computes out_sum[c] = sum_r in_data[r] * W[r][c] for each accepted input vector.
// Weights are loaded one row per beat in IDLE/LOAD and stay fixed through RUN/DRAIN.
// Input elements are skewed into the array and column results are deskewed so that
// a whole result vector leaves together, ROWS+COLS cycles after its input handshake.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   w_valid/w_ready/w_row    weight row stream (element c at [c*DATA_SIZE +: DATA_SIZE])
//   in_valid/in_ready/in_data input vector stream (element r at [r*DATA_SIZE +: DATA_SIZE])
//   out_valid/out_ready/out_sum result stream (element c at [c*ACC_SIZE +: ACC_SIZE])
//   flush                end of batch: drain the pipeline, then return to IDLE
//   busy                 high in any state other than IDLE
module systolic_array_engine #(
  parameter int unsigned ROWS      = 4,
  parameter int unsigned COLS      = 4,
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned ACC_SIZE  = 40
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic [COLS*DATA_SIZE-1:0] w_row,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROWS*DATA_SIZE-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [COLS*ACC_SIZE-1:0]  out_sum,
  input  logic                      flush,
  output logic                      busy
);

  localparam int unsigned CW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned TAGS = ROWS + COLS - 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          w_we;
  logic [CW-1:0] w_sel;
  logic          adv;
  logic          in_hs;
  logic [TAGS-1:0] vt_q;

  logic signed [DATA_SIZE-1:0] w_q  [ROWS][COLS];
  logic signed [DATA_SIZE-1:0] a_in [ROWS];
  logic [COLS*DATA_SIZE-1:0]   op   [ROWS];
  logic signed [ACC_SIZE-1:0]  ps_q [ROWS][COLS];
  logic signed [ACC_SIZE-1:0]  dsk  [COLS];

  // Signed DATA x DATA product, sign-extended to the accumulator width.
  function automatic logic signed [ACC_SIZE-1:0] mac_term(
    input logic signed [DATA_SIZE-1:0] a,
    input logic signed [DATA_SIZE-1:0] b
  );
    logic signed [2*DATA_SIZE-1:0] p;
    p = (2*DATA_SIZE)'(a) * (2*DATA_SIZE)'(b);
    return ACC_SIZE'(p);
  endfunction

  // Global stall: nothing moves while a result waits on the sink.
  assign adv      = !out_valid || out_ready;
  assign w_ready  = (state_q == IDLE) || (state_q == LOAD);
  assign in_ready = (state_q == RUN) && adv;
  assign busy     = (state_q != IDLE);
  assign in_hs    = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and weight-write decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_we    = 1'b0;
    w_sel   = cnt_q;
    case (state_q)
      IDLE: begin
        if (w_valid) begin
          w_we  = 1'b1;
          w_sel = '0;
          if (ROWS == 1) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            state_d = LOAD;
            cnt_d   = CW'(1);
          end
        end
      end
      LOAD: begin
        if (w_valid) begin
          w_we = 1'b1;
          if (cnt_q == CW'(ROWS - 1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      RUN: begin
        if (flush) state_d = DRAIN;
      end
      DRAIN: begin
        if ((vt_q == '0) && !out_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stationary weight storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) w_q[r][c] <= '0;
    end else if (w_we) begin
      for (int r = 0; r < ROWS; r++)
        if (w_sel == CW'(r))
          for (int c = 0; c < COLS; c++) w_q[r][c] <= w_row[c*DATA_SIZE +: DATA_SIZE];
    end
  end

  // Input skew (row r delayed r cycles) and horizontal operand pass-through.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    if (r == 0) begin : g_direct
      assign a_in[r] = in_data[0 +: DATA_SIZE];
    end else begin : g_skew
      logic [DATA_SIZE-1:0] sr [r];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < r; i++) sr[i] <= '0;
        end else if (adv) begin
          sr[0] <= in_data[r*DATA_SIZE +: DATA_SIZE];
          for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
        end
      end
      assign a_in[r] = sr[r-1];
    end

    if (COLS == 1) begin : g_one_col
      assign op[r] = a_in[r];
    end else begin : g_pass
      logic [(COLS-1)*DATA_SIZE-1:0] pass_q;
      always_ff @(posedge clk) begin
        if (reset)    pass_q <= '0;
        else if (adv) pass_q <= op[r][(COLS-1)*DATA_SIZE-1:0];
      end
      assign op[r] = {pass_q, a_in[r]};
    end
  end

  // PE grid: partial sums flow down each column, row 0 starts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) ps_q[r][c] <= '0;
    end else if (adv) begin
      for (int c = 0; c < COLS; c++) begin
        ps_q[0][c] <= mac_term(op[0][c*DATA_SIZE +: DATA_SIZE], w_q[0][c]);
        for (int r = 1; r < ROWS; r++)
          ps_q[r][c] <= ps_q[r-1][c] + mac_term(op[r][c*DATA_SIZE +: DATA_SIZE], w_q[r][c]);
      end
    end
  end

  // Output deskew: column c delayed COLS-1-c cycles to realign the vector.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int unsigned DEPTH = COLS - 1 - c;
    if (DEPTH == 0) begin : g_direct
      assign dsk[c] = ps_q[ROWS-1][c];
    end else begin : g_deskew
      logic signed [ACC_SIZE-1:0] dr [DEPTH];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) dr[i] <= '0;
        end else if (adv) begin
          dr[0] <= ps_q[ROWS-1][c];
          for (int i = 1; i < DEPTH; i++) dr[i] <= dr[i-1];
        end
      end
      assign dsk[c] = dr[DEPTH-1];
    end
  end

  // Valid tags travel alongside the data; the output register holds under stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      vt_q      <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else if (adv) begin
      vt_q      <= (vt_q << 1) | TAGS'(in_hs);
      out_valid <= vt_q[TAGS-1];
      if (vt_q[TAGS-1])
        for (int c = 0; c < COLS; c++) out_sum[c*ACC_SIZE +: ACC_SIZE] <= dsk[c];
    end
  end

endmodule

// File: tb/tb_systolic_array_engine.sv
// Self-checking bench for systolic_array_engine: a 40-bit and a 32-bit accumulator
// instance share all inputs; a queue-based matrix-product model supplies expected vectors.
module tb_systolic_array_engine;

  localparam int unsigned R  = 4;
  localparam int unsigned C  = 4;
  localparam int unsigned D  = 16;
  localparam int unsigned A  = 40;
  localparam int unsigned A2 = 32;

  logic clk = 1'b0;
  logic reset, w_valid, in_valid, out_ready, flush;
  logic [C*D-1:0] w_row;
  logic [R*D-1:0] in_data;
  logic w_ready, in_ready, out_valid, busy;
  logic [C*A-1:0] out_sum;
  logic w_ready2, in_ready2, out_valid2, busy2;
  logic [C*A2-1:0] out_sum2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int wm [R][C];
  logic [R*D-1:0]  xs [$];
  logic [C*64-1:0] exp_q [$];
  int hc_q [$];
  int oc_q [$];
  logic [63:0] last_out40, last_out32;

  systolic_array_engine #(.ROWS(R), .COLS(C), .DATA_SIZE(D), .ACC_SIZE(A)) dut (
    .clk(clk), .reset(reset), .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .flush(flush), .busy(busy));

  systolic_array_engine #(.ROWS(R), .COLS(C), .DATA_SIZE(D), .ACC_SIZE(A2)) dut32 (
    .clk(clk), .reset(reset), .w_valid(w_valid), .w_ready(w_ready2), .w_row(w_row),
    .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2),
    .flush(flush), .busy(busy2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // y[c] = sum_r x[r]*W[r][c] in 64-bit arithmetic; lower bits give each accumulator width.
  function automatic logic [C*64-1:0] model(input logic [R*D-1:0] x);
    logic [C*64-1:0] res;
    logic signed [D-1:0] xe;
    longint s;
    for (int c = 0; c < C; c++) begin
      s = 0;
      for (int r = 0; r < R; r++) begin
        xe = x[r*D +: D];
        s += longint'(xe) * longint'(wm[r][c]);
      end
      res[c*64 +: 64] = s;
    end
    return res;
  endfunction

  function automatic logic [R*D-1:0] pack4(input int e0, input int e1, input int e2, input int e3);
    return {D'(e3), D'(e2), D'(e1), D'(e0)};
  endfunction

  task automatic check_vec(input string tag, input logic [C*64-1:0] v);
    logic [63:0] e;
    chk({tag, "_valid32"}, 64'(out_valid2), 64'd1);
    for (int c = 0; c < C; c++) begin
      e = v[c*64 +: 64];
      chk({tag, "_acc40"}, 64'(out_sum[c*A +: A]), {24'd0, e[39:0]});
      chk({tag, "_acc32"}, 64'(out_sum2[c*A2 +: A2]), {32'd0, e[31:0]});
    end
  endtask

  // Scoreboard: sampled on the falling edge, between active edges.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data));
        hc_q.push_back(cyc);
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        if (exp_q.size() > 0) check_vec("stall_hold", exp_q[0]);
      end
      if (out_valid && out_ready) begin
        oc_q.push_back(cyc);
        last_out40 = 64'(out_sum[A-1:0]);
        last_out32 = 64'(out_sum2[A2-1:0]);
        chk("out_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) check_vec("out", exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads wm row by row; optional flush during the load must be ignored.
  task automatic load_w(input logic fl);
    for (int r = 0; r < R; r++) begin
      w_valid = 1'b1;
      flush   = fl;
      for (int c = 0; c < C; c++) w_row[c*D +: D] = D'(wm[r][c]);
      #1;
      chk("w_ready_beat", 64'(w_ready), 64'd1);
      tick();
    end
    w_valid = 1'b0;
    flush   = 1'b0;
    chk("run_in_ready", 64'(in_ready), 64'd1);
    chk("run_busy", 64'(busy), 64'd1);
  endtask

  // Streams xs[0..n-1]; out_ready low for stall_len cycles from loop step stall_at.
  task automatic stream(input int n, input int stall_at, input int stall_len, input logic fl_last);
    int sent = 0;
    logic fl_hs;
    for (int k = 0; k < 400; k++) begin
      if (sent >= n && exp_q.size() == 0 && !out_valid) break;
      in_valid = (sent < n);
      in_data  = '0;
      if (sent < n) in_data = xs[sent];
      flush     = fl_last && (sent == n - 1);
      out_ready = !(k >= stall_at && k < stall_at + stall_len);
      #1;
      fl_hs = flush && in_valid && in_ready;
      if (in_valid && in_ready) sent++;
      tick();
      if (fl_hs) begin
        chk("drain_busy", 64'(busy), 64'd1);
        chk("drain_in_ready", 64'(in_ready), 64'd0);
        chk("drain_w_ready", 64'(w_ready), 64'd0);
      end
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    chk("stream_done", 64'(sent == n && exp_q.size() == 0), 64'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50 && busy; k++) tick();
    chk("back_to_idle", 64'(busy), 64'd0);
    chk("idle_w_ready", 64'(w_ready), 64'd1);
  endtask

  task automatic to_idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle();
  endtask

  task automatic rand_w();
    logic signed [D-1:0] t;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        t = D'($urandom);
        wm[r][c] = t;
      end
  endtask

  initial begin
    reset = 1'b1; w_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    w_row = '0; in_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_w_ready", 64'(w_ready), 64'd1);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum != '0), 64'd0);

    // Flush in IDLE is ignored.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("idle_flush_busy", 64'(busy), 64'd0);

    // Identity weights, latency of the first vector.
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wm[r][c] = (r == c) ? 1 : 0;
    load_w(1'b1);
    xs.delete(); hc_q.delete(); oc_q.delete();
    xs.push_back(pack4(1, 2, 3, 4));
    xs.push_back(pack4(-5, 6, -7, 8));
    stream(2, 1000, 0, 1'b0);
    chk("latency_first", 64'(oc_q.size() > 0 ? oc_q[0] - hc_q[0] : -1), 64'd8);
    to_idle();

    // W[r][c] = r+1, 20 back-to-back all-ones vectors.
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wm[r][c] = r + 1;
    load_w(1'b0);
    xs.delete(); hc_q.delete(); oc_q.delete();
    for (int i = 0; i < 20; i++) xs.push_back(pack4(1, 1, 1, 1));
    stream(20, 1000, 0, 1'b0);
    chk("burst_count", 64'(oc_q.size()), 64'd20);
    chk("burst_span", 64'(oc_q.size() == 20 ? oc_q[19] - oc_q[0] : -1), 64'd19);

    // Random 20-vector burst with a 5-cycle sink stall mid-burst.
    xs.delete(); hc_q.delete(); oc_q.delete();
    for (int i = 0; i < 20; i++) xs.push_back({$urandom, $urandom});
    stream(20, 12, 5, 1'b0);
    chk("stall_count", 64'(oc_q.size()), 64'd20);
    chk("stall_span", 64'(oc_q.size() == 20 ? oc_q[19] - oc_q[0] : -1), 64'd24);
    chk("stall_last_latency", 64'(oc_q.size() == 20 ? oc_q[19] - hc_q[19] : -1), 64'd8);
    to_idle();

    // Extreme operands: no overflow at 40 bits, wrap at 32 bits.
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) wm[r][c] = 32767;
    load_w(1'b0);
    xs.delete();
    xs.push_back(pack4(-32768, -32768, -32768, -32768));
    stream(1, 1000, 0, 1'b0);
    chk("extreme_acc40", last_out40, 64'hFF_0002_0000);
    chk("extreme_acc32", last_out32, 64'h0002_0000);
    to_idle();

    // Random weights; flush together with the final handshake, then reload.
    rand_w();
    load_w(1'b0);
    xs.delete();
    for (int i = 0; i < 5; i++) xs.push_back({$urandom, $urandom});
    stream(5, 1000, 0, 1'b1);
    wait_idle();
    rand_w();
    load_w(1'b0);
    xs.delete();
    for (int i = 0; i < 10; i++) xs.push_back({$urandom, $urandom});
    stream(10, 3, 2, 1'b0);

    // Reset in RUN with three vectors in flight: nothing may come out afterwards.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = {$urandom, $urandom};
      #1;
      chk("inflight_in_ready", 64'(in_ready), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_w_ready", 64'(w_ready), 64'd1);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_out_sum", 64'(out_sum != '0 || out_sum2 != '0), 64'd0);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("no_stale_out", 64'(out_valid | out_valid2), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_array_engine.md
Name: systolic_array_engine

Overview:
- Parametrised weight-stationary systolic matrix-multiply engine with separate row/column counts, a widened accumulator and internal input skew/output deskew.
- Adds valid/ready streaming, global backpressure stall and a weight-load/run/drain state machine.
- Computes out_sum[c] = sum over r of in_data[r]*W[r][c] per accepted input vector.
- Sits between an input-vector feeder and a result sink in the accelerator datapath.

Parameters:
- ROWS, 4, array rows = input vector length = weight rows (>=1).
- COLS, 4, array columns = output vector length (>=1).
- DATA_SIZE, 16, signed two's-complement width of data and weight elements.
- ACC_SIZE, 40, signed accumulator/output element width (>= 2*DATA_SIZE).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- w_valid  in  1  weight row beat valid.
- w_ready  out  1  weight row beat accepted when w_valid&w_ready.
- w_row  in  COLS*DATA_SIZE  weight row; element c at bits [c*DATA_SIZE +: DATA_SIZE].
- in_valid  in  1  input vector valid.
- in_ready  out  1  input vector accepted when in_valid&in_ready.
- in_data  in  ROWS*DATA_SIZE  input vector; element r at [r*DATA_SIZE +: DATA_SIZE].
- out_valid  out  1  result vector valid.
- out_ready  in  1  sink accepts result.
- out_sum  out  COLS*ACC_SIZE  result vector; element c at [c*ACC_SIZE +: ACC_SIZE].
- flush  in  1  end-of-batch request; drain pipeline, then return to IDLE.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, row counter=0, all weights=0, all pipeline valid tags=0, out_valid=0, out_sum=0, w_ready=1, in_ready=0, busy=0. Reset mid-operation discards all in-flight vectors; no partial output is emitted.
- States:
  - IDLE: w_ready=1. The first w_valid beat is written to weight row 0; go to LOAD with counter=1 (if ROWS==1, go directly to RUN).
  - LOAD: w_ready=1. Each beat writes row[counter] and increments counter. The beat that writes row ROWS-1 moves to RUN and clears counter.
  - RUN: w_ready=0, in_ready=adv. flush=1 moves to DRAIN; an input handshake in the same cycle is still accepted.
  - DRAIN: in_ready=0, w_ready=0. Move to IDLE in the cycle after all valid tags and out_valid are 0 (final out handshake complete).
- A flush seen in IDLE or LOAD is ignored.
- adv = !out_valid | out_ready. When adv=0, all skew, PE, deskew and valid-tag registers hold (global stall). out_valid and out_sum stay stable until the handshake.
- Skew: element r is delayed r extra cycles before entering row r. Deskew: column c output is delayed COLS-1-c extra cycles so that all columns of one vector emerge together.
- Latency: with adv held 1, out_valid rises exactly ROWS+COLS cycles after the input handshake cycle. Throughput is 1 vector/cycle. Order is preserved. Bubbles (no handshake) carry valid tag 0 and produce no output.
- Arithmetic: product is DATA_SIZE x DATA_SIZE signed, sign-extended to ACC_SIZE. Partial sums add modulo 2^ACC_SIZE (wrap, no saturation). Row 0 partial-sum input is 0.
- Weights are stationary: they are loaded only in IDLE/LOAD and are unchanged through RUN/DRAIN. Reloading requires a flush first.
- busy=1 in LOAD, RUN, DRAIN.

Test Plan:
- Load identity W (4x4); stream x=[1,2,3,4] then [-5,6,-7,8] -> outputs [1,2,3,4] then [-5,6,-7,8], first out_valid exactly 8 cycles after first in handshake.
- W[r][c]=r+1 for all c; x=[1,1,1,1] -> out_sum=[10,10,10,10]. Back-to-back 20 vectors -> 20 outputs on 20 consecutive cycles, correct order.
- Same stream with out_ready low for 5 cycles mid-burst -> in_ready low while stalled, out_sum stable, no loss or duplication, latency resumes.
- W all 0x7FFF, x all 0x8000, DATA_SIZE=16 -> each column equals 4*(-32767*32768)=-4294836224, no overflow in 40 bits. Separately, ACC_SIZE=32 with the same values -> result wraps modulo 2^32.
- Assert flush with the final input handshake -> that vector is still output; state DRAIN, then IDLE; busy falls; w_ready rises. A new weight load then gives results with the new W.
- Assert reset in RUN with 3 vectors in flight -> next cycle out_valid=0, state IDLE, weights 0. No stale outputs appear afterwards.
